md_sched: RTL

//  E-stage sequencer for the multiply/divide resource: accepts one md op per start, owns HI/LO,

---
 rtl/md_sched.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/md_sched.sv
// ---------------------------------------------------------------------------
// md_sched -- E-stage sequencer for the multiply/divide resource.
//
// Accepts one md op per start pulse, owns the architectural HI/LO pair and
// models the fixed mult/div latency with a down-counter. The result is
// computed at the start edge into pending registers and committed to HI/LO
// when the counter expires. A divide by zero still occupies the unit for the
// full divide latency, but leaves HI/LO untouched.
//
// Parameters
//   MULT_CYCLES  busy cycles for mult/multu (1..15)
//   DIV_CYCLES   busy cycles for div/divu  (1..15)
//
// Ports
//   clk       in   1   rising-edge clock
//   reset     in   1   asynchronous reset, active-low
//   start     in   1   E stage holds a valid md op this cycle
//   md_op     in   4   1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
//   rs        in   32  forwarded rs operand
//   rt        in   32  forwarded rt operand
//   md_in_d   in   1   D stage holds an md-class instruction
//   busy      out  1   registered, high while an op is in flight
//   done      out  1   registered one-cycle pulse after HI/LO commit
//   stall_md  out  1   combinational stall request to the hazard unit
//   hi        out  32  architectural HI
//   lo        out  32  architectural LO
// ---------------------------------------------------------------------------
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        md_in_d,
    output logic        busy,
    output logic        done,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    // Counter reload values: the counter runs N-1 .. 0, giving N busy cycles.
    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_wr;

    state_t      w_state_nxt;
    logic [3:0]  w_cnt_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;
    logic [31:0] w_pend_hi_nxt;
    logic [31:0] w_pend_lo_nxt;
    logic        w_pend_wr_nxt;

    logic        w_long_op;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_is_signed_div;
    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [31:0] w_div_a;
    logic [31:0] w_div_b;
    logic [31:0] w_div_b_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_long_op = start & (md_op >= OP_MULT) & (md_op <= OP_DIVU);

    // Products: operands are explicitly extended to 64 bits so the low 64 bits
    // of the product are the exact result.
    assign w_prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    assign w_prod_u = {32'd0, rs} * {32'd0, rt};

    // Signed divide is done on magnitudes so that 0x80000000 / -1 and the
    // truncation-toward-zero rule fall out without any overflow special case:
    // |0x80000000| is still 0x80000000 as an unsigned value.
    assign w_is_signed_div = (md_op == OP_DIV);
    assign w_rs_neg        = w_is_signed_div & rs[31];
    assign w_rt_neg        = w_is_signed_div & rt[31];
    assign w_div_a         = w_rs_neg ? (32'd0 - rs) : rs;
    assign w_div_b         = w_rt_neg ? (32'd0 - rt) : rt;
    assign w_div_b_safe    = (w_div_b == 32'd0) ? 32'd1 : w_div_b;
    assign w_q_mag         = w_div_a / w_div_b_safe;
    assign w_r_mag         = w_div_a % w_div_b_safe;
    assign w_quot          = (w_rs_neg ^ w_rt_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem           = w_rs_neg ? (32'd0 - w_r_mag) : w_r_mag;

    // Next-state and next-register values for the sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        w_pend_wr_nxt = r_pend_wr;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (md_op)
                        OP_MULT: begin
                            w_pend_hi_nxt = w_prod_s[63:32];
                            w_pend_lo_nxt = w_prod_s[31:0];
                            w_pend_wr_nxt = 1'b1;
                            w_cnt_nxt     = MULT_LOAD;
                            w_busy_nxt    = 1'b1;
                            w_state_nxt   = S_RUN;
                        end
                        OP_MULTU: begin
                            w_pend_hi_nxt = w_prod_u[63:32];
                            w_pend_lo_nxt = w_prod_u[31:0];
                            w_pend_wr_nxt = 1'b1;
                            w_cnt_nxt     = MULT_LOAD;
                            w_busy_nxt    = 1'b1;
                            w_state_nxt   = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            w_pend_hi_nxt = w_rem;
                            w_pend_lo_nxt = w_quot;
                            // Divide by zero runs the full latency but never commits.
                            w_pend_wr_nxt = (rt != 32'd0);
                            w_cnt_nxt     = DIV_LOAD;
                            w_busy_nxt    = 1'b1;
                            w_state_nxt   = S_RUN;
                        end
                        OP_MTHI: begin
                            w_hi_nxt = rs;
                        end
                        OP_MTLO: begin
                            w_lo_nxt = rs;
                        end
                        default: begin
                            w_state_nxt = S_IDLE;
                        end
                    endcase
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                // Any start arriving here is ignored; the hazard unit prevents it.
                if (r_cnt == 4'd0) begin
                    if (r_pend_wr) begin
                        w_hi_nxt = r_pend_hi;
                        w_lo_nxt = r_pend_lo;
                    end else begin
                        w_hi_nxt = r_hi;
                    end
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Sequencer state, counter, HI/LO and pending result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
            r_pend_wr <= w_pend_wr_nxt;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign hi       = r_hi;
    assign lo       = r_lo;
    // A long op being issued this cycle must hold D even before busy rises.
    assign stall_md = md_in_d & (r_busy | w_long_op);

endmodule
